// File: rtl/serial_multiplier_p.sv
// Shift-and-add multiplier: one multiplier bit per cycle, optional early exit once the remaining multiplier bits are all zero.
// Signed operands are converted to magnitudes on capture, and the sign is applied once at completion.
module serial_multiplier_p #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic [2*WIDTH-1:0]   out,
    output logic                 done,
    output logic                 busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   mcand, acc, acc_nxt;
    logic [WIDTH-1:0]     mplier, mplier_nxt, mag1, mag2;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 neg;
    logic                 capture, finish;

    // Unary minus of -2^(WIDTH-1) wraps back to 2^(WIDTH-1), which is the correct unsigned magnitude
    always_comb begin
        mag1       = (signed_mode && in1[WIDTH-1]) ? -in1 : in1;
        mag2       = (signed_mode && in2[WIDTH-1]) ? -in2 : in2;
        acc_nxt    = acc + (mplier[0] ? mcand : '0);
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt + CW'(1);
        finish     = (cnt_nxt == CW'(WIDTH)) || (EARLY_EXIT && (mplier_nxt == '0));
        capture    = start && ((state == S_IDLE) || (state == S_DONE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (finish) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        done = (state == S_DONE);
        busy = (state == S_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            out    <= '0;
        end else if (capture) begin
            mcand  <= {{WIDTH{1'b0}}, mag1};
            mplier <= mag2;
            acc    <= '0;
            cnt    <= '0;
            neg    <= signed_mode & (in1[WIDTH-1] ^ in2[WIDTH-1]);
        end else if (state == S_RUN) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier_nxt;
            cnt    <= cnt_nxt;
            if (finish) out <= neg ? -acc_nxt : acc_nxt;
        end
    end
endmodule

// File: doc/serial_multiplier_p.md
SERIAL_MULTIPLIER_P -- requirements
Module: serial_multiplier_p

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; legal range 2..32.
REQ-002 Parameter: EARLY_EXIT, 1, 1 = stop once remaining multiplier bits are zero; 0 = always run WIDTH cycles.
REQ-003 Port: clk  input  1  sole clock, rising-edge active.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  request; sampled only when busy=0.
REQ-006 Port: signed_mode  input  1  1 = two's-complement operands; 0 = unsigned; sampled with start.
REQ-007 Port: in1  input  WIDTH  multiplicand; sampled with start.
REQ-008 Port: in2  input  WIDTH  multiplier; sampled with start.
REQ-009 Port: out  output  2*WIDTH  product register; changes only on completion or reset.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: busy  output  1  high while an operation is in progress.

Function
REQ-012 The design SHALL implement a three-state FSM: IDLE, RUN, DONE; the encoding is free.
REQ-013 IDLE: start=1 at a rising edge SHALL capture operands and mode and move to RUN; otherwise stay in IDLE.
REQ-014 DONE SHALL last exactly one cycle. If start=1 at its edge, the block SHALL accept a new operation and go to RUN (back-to-back); otherwise it SHALL go to IDLE.
REQ-015 Start while in RUN SHALL be ignored; operands, mode and progress SHALL be unaffected.
REQ-016 On capture, signed_mode=1 SHALL store |in1| and |in2| as WIDTH-bit unsigned magnitudes and store neg = in1[MSB] XOR in2[MSB]. signed_mode=0 SHALL store in1 and in2 as-is with neg=0.
REQ-017 Magnitude of -2^(WIDTH-1) SHALL be 2^(WIDTH-1), with no overflow.
REQ-018 Each RUN edge SHALL:
  - add the 2*WIDTH-bit multiplicand register to the accumulator if multiplier bit0=1;
  - shift the multiplicand left by 1;
  - shift the multiplier right by 1;
  - increment a bit counter.
REQ-019 RUN SHALL end at the edge where the counter reaches WIDTH, or, when EARLY_EXIT=1, at the edge where the shifted multiplier becomes zero; whichever comes first.
REQ-020 RUN length R SHALL be:
  - EARLY_EXIT=0: R = WIDTH;
  - EARLY_EXIT=1: R = (index of highest set bit of the multiplier magnitude)+1, with R=1 when it is zero.
REQ-021 At the RUN-exit edge, out SHALL load the final accumulator value, two's-complement negated when neg=1, and the state SHALL become DONE.
REQ-022 Latency: with start sampled at edge N, done=1 SHALL hold for the cycle after edge N+R, and out SHALL be valid from that cycle.
REQ-023 done SHALL be 1 only in DONE. busy SHALL be 1 only in RUN.
REQ-024 out SHALL hold its value through IDLE, DONE and subsequent RUN until the next completion.
REQ-025 The accumulator SHALL be cleared at every operand capture; it is never visible on out mid-operation.
REQ-026 All arithmetic SHALL be modulo 2^(2*WIDTH). The full product SHALL always fit, with no truncation.

Reset
REQ-027 reset=1 SHALL immediately, without a clock edge, force: state IDLE, out=0, done=0, busy=0, accumulator=0, counter=0, operand registers=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no completion pulse. The first start after reset deasserts SHALL behave per REQ-013.
REQ-029 Outputs SHALL be glitch-free registered values; done and busy are decoded from the state register only.

Verification
REQ-030 WIDTH=16, EARLY_EXIT=1, unsigned 3*5 -> busy high 3 cycles; done pulse 1 cycle; out=32'h0000000F.
REQ-031 Unsigned 16'hFFFF*16'hFFFF -> R=16; out=32'hFFFE0001. Unsigned 16'h1234*0 -> R=1; out=0.
REQ-032 Signed -3*7 -> out=32'hFFFFFFEB. Signed 16'h8000*16'h8000 -> out=32'h40000000. Signed 16'h8000*1 -> out=32'hFFFF8000.
REQ-033 Start pulsed mid-RUN with different operands -> ignored, first result unchanged. Start held high through DONE -> second operation begins with no IDLE cycle, and out keeps the first result until the second completes.
REQ-034 Reset asserted at RUN cycle 5 of 16'hFFFF*16'hFFFF -> out, done and busy go to 0 asynchronously. A following 6*7 (EARLY_EXIT=1) -> out=42 after 3 RUN cycles.
REQ-035 EARLY_EXIT=0, WIDTH=8, unsigned 8'd1*8'd1 -> busy high 8 cycles; out=16'h0001.
